// File: rtl/rom_fetch_arbiter_pkg.sv
// ============================================================================
// Module : rom_arb_pkg
// Brief  : Shared types and widths for the ROM fetch arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rom_arb_pkg;

    localparam int ADDR_W = 31;
    localparam int DATA_W = 32;

    // Arbitration mode: fetch-first, or debug-first after starvation
    typedef enum logic [0:0] {
        NORMAL   = 1'b0,
        DBG_PRIO = 1'b1
    } arb_state_e;

    // Identity of the requester that owns the ROM this cycle
    typedef enum logic [0:0] {
        REQ_F = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

endpackage

`default_nettype wire

// File: rtl/rom_fetch_arbiter_if.sv
// ============================================================================
// Module : rom_fetch_arbiter_if
// Brief  : Fetch port, debug port and ROM side signals of the arbiter.
//          slave  = arbiter side, master = requesters / ROM side.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rom_fetch_arbiter_if;
    import rom_arb_pkg::*;

    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;
    logic              f_err;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    modport slave (
        input  f_req, f_addr, d_req, d_addr, rom_data,
        output f_gnt, f_rvalid, f_rdata, f_err,
               d_gnt, d_rvalid, d_rdata, d_err, rom_addr
    );

    modport master (
        output f_req, f_addr, d_req, d_addr, rom_data,
        input  f_gnt, f_rvalid, f_rdata, f_err,
               d_gnt, d_rvalid, d_rdata, d_err, rom_addr
    );

endinterface

`default_nettype wire

// File: rtl/rom_fetch_arbiter_starve_ctr.sv
// ============================================================================
// Module : rom_arb_starve_ctr
// Brief  : Saturating starvation counter for pending debug requests and the
//          NORMAL / DBG_PRIO mode FSM. dbg_prio comes straight from the state
//          register so the grant logic has no combinational loop.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rom_arb_starve_ctr
    import rom_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  wire  clk,
    input  wire  reset,
    input  wire  d_req,
    input  wire  d_gnt,
    output logic dbg_prio
);

    localparam logic [7:0] C_LIMIT = 8'(STARVE_LIMIT);

    arb_state_e state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    // Next counter value and mode
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        case (state_q)
            NORMAL: begin
                if (!d_req || d_gnt) begin
                    cnt_d = 8'd0;
                end else if (cnt_q != C_LIMIT) begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (cnt_d == C_LIMIT) begin
                    state_d = DBG_PRIO;
                end
            end
            DBG_PRIO: begin
                // Debug always wins here, so it is either granted or withdrawn
                if (d_gnt || !d_req) begin
                    cnt_d   = 8'd0;
                    state_d = NORMAL;
                end
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = NORMAL;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= NORMAL;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dbg_prio = (state_q == DBG_PRIO);

endmodule

`default_nettype wire

// File: rtl/rom_fetch_arbiter.sv
// ============================================================================
// Module : rom_fetch_arbiter
// Brief  : Shares one combinational instruction ROM between CPU fetch (F) and
//          debug readback (D). Fetch has fixed priority; a starvation guard
//          forces periodic debug service. Read data is registered and returned
//          one cycle after the grant, with alignment/range checking.
//          Optional macro ROM_ARB_STATS_EN adds saturating statistics counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rom_fetch_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ROM_WORDS    = 64,
    parameter int STARVE_LIMIT = 8
`ifdef ROM_ARB_STATS_EN
    ,
    parameter int CNT_W        = 16
`endif
) (
    input  wire                 clk,
    input  wire                 reset,
    rom_fetch_arbiter_if.slave  bus
`ifdef ROM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]    f_cnt,
    output logic [CNT_W-1:0]    d_cnt,
    output logic [CNT_W-1:0]    err_cnt,
    output logic [CNT_W-1:0]    stall_cnt
`endif
);

    localparam logic [ADDR_W-3:0] C_ROM_WORDS = (ADDR_W-2)'(ROM_WORDS);

    logic              w_dbg_prio;
    logic              w_f_gnt;
    logic              w_d_gnt;
    req_id_e           w_sel_id;
    logic [ADDR_W-1:0] w_rom_addr;
    logic              w_err;
    logic [DATA_W-1:0] w_resp_data;

    logic              f_rvalid_q, f_rvalid_d;
    logic [DATA_W-1:0] f_rdata_q,  f_rdata_d;
    logic              f_err_q,    f_err_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] d_rdata_q,  d_rdata_d;
    logic              d_err_q,    d_err_d;

    rom_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk      (clk),
        .reset    (reset),
        .d_req    (bus.d_req),
        .d_gnt    (w_d_gnt),
        .dbg_prio (w_dbg_prio)
    );

    // Grant selection, ROM address mux and access checking
    always_comb begin
        w_f_gnt     = bus.f_req && !(w_dbg_prio && bus.d_req);
        w_d_gnt     = bus.d_req && (w_dbg_prio || !bus.f_req);
        w_sel_id    = w_d_gnt ? REQ_D : REQ_F;
        w_rom_addr  = '0;
        if (w_f_gnt || w_d_gnt) begin
            w_rom_addr = (w_sel_id == REQ_D) ? bus.d_addr : bus.f_addr;
        end
        w_err       = (w_rom_addr[1:0] != 2'b00) ||
                      (w_rom_addr[ADDR_W-1:2] >= C_ROM_WORDS);
        w_resp_data = w_err ? '0 : bus.rom_data;
    end

    // Response capture: rvalid pulses for one cycle, data/err hold until next
    always_comb begin
        f_rvalid_d = w_f_gnt;
        f_rdata_d  = w_f_gnt ? w_resp_data : f_rdata_q;
        f_err_d    = w_f_gnt ? w_err       : f_err_q;
        d_rvalid_d = w_d_gnt;
        d_rdata_d  = w_d_gnt ? w_resp_data : d_rdata_q;
        d_err_d    = w_d_gnt ? w_err       : d_err_q;
    end

    // Response registers; reset drops any in-flight response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_rvalid_q <= 1'b0;
            f_rdata_q  <= '0;
            f_err_q    <= 1'b0;
            d_rvalid_q <= 1'b0;
            d_rdata_q  <= '0;
            d_err_q    <= 1'b0;
        end else begin
            f_rvalid_q <= f_rvalid_d;
            f_rdata_q  <= f_rdata_d;
            f_err_q    <= f_err_d;
            d_rvalid_q <= d_rvalid_d;
            d_rdata_q  <= d_rdata_d;
            d_err_q    <= d_err_d;
        end
    end

    assign bus.f_gnt    = w_f_gnt;
    assign bus.d_gnt    = w_d_gnt;
    assign bus.rom_addr = w_rom_addr;
    assign bus.f_rvalid = f_rvalid_q;
    assign bus.f_rdata  = f_rdata_q;
    assign bus.f_err    = f_err_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.d_err    = d_err_q;

`ifdef ROM_ARB_STATS_EN
    logic [CNT_W-1:0] f_cnt_q,     f_cnt_d;
    logic [CNT_W-1:0] d_cnt_q,     d_cnt_d;
    logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             w_err_resp;
    logic             w_stall;

    // Saturating statistics increments
    always_comb begin
        w_err_resp  = (f_rvalid_q && f_err_q) || (d_rvalid_q && d_err_q);
        w_stall     = (bus.f_req && !w_f_gnt) || (bus.d_req && !w_d_gnt);
        f_cnt_d     = (w_f_gnt    && (f_cnt_q     != '1)) ? f_cnt_q     + 1'b1 : f_cnt_q;
        d_cnt_d     = (w_d_gnt    && (d_cnt_q     != '1)) ? d_cnt_q     + 1'b1 : d_cnt_q;
        err_cnt_d   = (w_err_resp && (err_cnt_q   != '1)) ? err_cnt_q   + 1'b1 : err_cnt_q;
        stall_cnt_d = (w_stall    && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    // Statistics registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_cnt_q     <= '0;
            d_cnt_q     <= '0;
            err_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            f_cnt_q     <= f_cnt_d;
            d_cnt_q     <= d_cnt_d;
            err_cnt_q   <= err_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign f_cnt     = f_cnt_q;
    assign d_cnt     = d_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rom_fetch_arbiter.sv
// ============================================================================
// Module : tb_rom_fetch_arbiter
// Brief  : Self-checking bench for rom_fetch_arbiter (table vectors plus
//          hand-written multi-cycle sequences). Stats checks build only with
//          ROM_ARB_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rom_fetch_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    rom_fetch_arbiter_if bus();

`ifdef ROM_ARB_STATS_EN
    logic [15:0] f_cnt, d_cnt, err_cnt, stall_cnt;
`endif

    rom_fetch_arbiter #(
        .ROM_WORDS    (64),
        .STARVE_LIMIT (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave)
`ifdef ROM_ARB_STATS_EN
        ,
        .f_cnt     (f_cnt),
        .d_cnt     (d_cnt),
        .err_cnt   (err_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ROM contents model: distinct value per word index
    function automatic logic [31:0] rom_word(input logic [30:0] a);
        logic [31:0] idx;
        idx = {3'b000, a[30:2]};
        return 32'hC0DE_0000 ^ (idx * 32'h0001_0101);
    endfunction

    function automatic logic [31:0] wexp(input int i);
        return rom_word(31'(i * 4));
    endfunction

    assign bus.rom_data = rom_word(bus.rom_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, then settle
    task automatic drive(input logic fr, input logic [30:0] fa,
                         input logic dr, input logic [30:0] da);
        @(negedge clk);
        bus.f_req  = fr;
        bus.f_addr = fa;
        bus.d_req  = dr;
        bus.d_addr = da;
        #1;
    endtask

    // Eight denied debug cycles followed by the forced debug grant
    task automatic starve_run(input string nm, input logic [30:0] da);
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 31'h20, 1'b1, da);
            chk({nm, "_fgnt"}, 32'(bus.f_gnt), 32'd1);
            chk({nm, "_dgnt"}, 32'(bus.d_gnt), 32'd0);
        end
        drive(1'b1, 31'h20, 1'b1, da);
        chk({nm, "_fgnt9"}, 32'(bus.f_gnt), 32'd0);
        chk({nm, "_dgnt9"}, 32'(bus.d_gnt), 32'd1);
    endtask

    typedef struct {
        logic        fr;
        logic [30:0] fa;
        logic        dr;
        logic [30:0] da;
        logic        fg;
        logic        dg;
        logic        fv;
        logic [31:0] fd;
        logic        fe;
        logic        dv;
        logic [31:0] dd;
        logic        de;
    } vec_t;

    vec_t vt[12];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        bus.f_req  = 1'b0;
        bus.f_addr = '0;
        bus.d_req  = 1'b0;
        bus.d_addr = '0;

        //          fr    fa        dr    da       fg dg fv fd         fe dv dd        de
        vt[0]  = '{1'b0, 31'h000, 1'b0, 31'h00, 0, 0, 0, 32'd0,     0, 0, 32'd0,    0};
        vt[1]  = '{1'b1, 31'h000, 1'b0, 31'h00, 1, 0, 0, 32'd0,     0, 0, 32'd0,    0};
        vt[2]  = '{1'b1, 31'h004, 1'b0, 31'h00, 1, 0, 1, wexp(0),   0, 0, 32'd0,    0};
        vt[3]  = '{1'b1, 31'h008, 1'b0, 31'h00, 1, 0, 1, wexp(1),   0, 0, 32'd0,    0};
        vt[4]  = '{1'b1, 31'h00C, 1'b1, 31'h10, 1, 0, 1, wexp(2),   0, 0, 32'd0,    0};
        vt[5]  = '{1'b0, 31'h000, 1'b1, 31'h10, 0, 1, 1, wexp(3),   0, 0, 32'd0,    0};
        vt[6]  = '{1'b0, 31'h000, 1'b0, 31'h00, 0, 0, 0, wexp(3),   0, 1, wexp(4),  0};
        vt[7]  = '{1'b1, 31'h102, 1'b0, 31'h00, 1, 0, 0, wexp(3),   0, 0, wexp(4),  0};
        vt[8]  = '{1'b1, 31'h100, 1'b0, 31'h00, 1, 0, 1, 32'd0,     1, 0, wexp(4),  0};
        vt[9]  = '{1'b1, 31'h0FC, 1'b0, 31'h00, 1, 0, 1, 32'd0,     1, 0, wexp(4),  0};
        vt[10] = '{1'b0, 31'h000, 1'b0, 31'h00, 0, 0, 1, wexp(63),  0, 0, wexp(4),  0};
        vt[11] = '{1'b0, 31'h000, 1'b0, 31'h00, 0, 0, 0, wexp(63),  0, 0, wexp(4),  0};

        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Table vectors: back-to-back fetch, contention, error cases
        for (int i = 0; i < 12; i++) begin
            drive(vt[i].fr, vt[i].fa, vt[i].dr, vt[i].da);
            chk($sformatf("v%0d_f_gnt", i),    32'(bus.f_gnt),    32'(vt[i].fg));
            chk($sformatf("v%0d_d_gnt", i),    32'(bus.d_gnt),    32'(vt[i].dg));
            chk($sformatf("v%0d_f_rvalid", i), 32'(bus.f_rvalid), 32'(vt[i].fv));
            chk($sformatf("v%0d_f_rdata", i),  bus.f_rdata,       vt[i].fd);
            chk($sformatf("v%0d_f_err", i),    32'(bus.f_err),    32'(vt[i].fe));
            chk($sformatf("v%0d_d_rvalid", i), 32'(bus.d_rvalid), 32'(vt[i].dv));
            chk($sformatf("v%0d_d_rdata", i),  bus.d_rdata,       vt[i].dd);
            chk($sformatf("v%0d_d_err", i),    32'(bus.d_err),    32'(vt[i].de));
        end

        // Starvation: debug served on the 9th cycle, then back to NORMAL
        starve_run("starve", 31'h14);
        drive(1'b1, 31'h24, 1'b1, 31'h18);
        chk("post_starve_fgnt",  32'(bus.f_gnt),    32'd1);
        chk("post_starve_dgnt",  32'(bus.d_gnt),    32'd0);
        chk("starve_d_rvalid",   32'(bus.d_rvalid), 32'd1);
        chk("starve_d_rdata",    bus.d_rdata,       wexp(5));
        drive(1'b0, 31'h0, 1'b0, 31'h0);

        // Debug withdraws while in DBG_PRIO: mode and counter must clear
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 31'h20, 1'b1, 31'h14);
            chk("drop_pre_dgnt", 32'(bus.d_gnt), 32'd0);
        end
        drive(1'b1, 31'h20, 1'b0, 31'h0);
        chk("drop_fgnt", 32'(bus.f_gnt), 32'd1);
        starve_run("drop", 31'h14);
        drive(1'b0, 31'h0, 1'b0, 31'h0);

        // Reset right behind a debug grant drops the response
        drive(1'b0, 31'h0, 1'b1, 31'h08);
        chk("rst_dgnt", 32'(bus.d_gnt), 32'd1);
        #1 reset = 1'b0;
        bus.d_req = 1'b0;
        drive(1'b0, 31'h0, 1'b0, 31'h0);
        chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        chk("rst_d_rdata",  bus.d_rdata,       32'd0);
        chk("rst_f_rdata",  bus.f_rdata,       32'd0);
        reset = 1'b1;
        drive(1'b0, 31'h0, 1'b0, 31'h0);
        chk("rst_d_rvalid2", 32'(bus.d_rvalid), 32'd0);

        // Reset with a partly filled starvation counter clears it
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 31'h20, 1'b1, 31'h14);
        end
        #1 reset = 1'b0;
        bus.f_req = 1'b0;
        bus.d_req = 1'b0;
        drive(1'b0, 31'h0, 1'b0, 31'h0);
        reset = 1'b1;
        starve_run("rst_starve", 31'h14);
        drive(1'b0, 31'h0, 1'b0, 31'h0);

`ifdef ROM_ARB_STATS_EN
        reset = 1'b0;
        drive(1'b0, 31'h0, 1'b0, 31'h0);
        reset = 1'b1;
        chk("stat_rst_f", 32'(f_cnt), 32'd0);
        drive(1'b1, 31'h000, 1'b0, 31'h0);
        drive(1'b1, 31'h004, 1'b1, 31'h8);
        drive(1'b0, 31'h000, 1'b1, 31'h8);
        drive(1'b1, 31'h102, 1'b0, 31'h0);
        drive(1'b1, 31'h008, 1'b1, 31'hC);
        drive(1'b1, 31'h00C, 1'b1, 31'hC);
        drive(1'b0, 31'h000, 1'b1, 31'hC);
        drive(1'b0, 31'h000, 1'b0, 31'h0);
        drive(1'b0, 31'h000, 1'b0, 31'h0);
        chk("stat_f_cnt",     32'(f_cnt),     32'd5);
        chk("stat_d_cnt",     32'(d_cnt),     32'd2);
        chk("stat_err_cnt",   32'(err_cnt),   32'd1);
        chk("stat_stall_cnt", 32'(stall_cnt), 32'd3);
        @(negedge clk);
        force dut.f_cnt_q = 16'hFFFF;
        #1 release dut.f_cnt_q;
        drive(1'b1, 31'h0, 1'b0, 31'h0);
        drive(1'b0, 31'h0, 1'b0, 31'h0);
        chk("stat_f_sat", 32'(f_cnt), 32'h0000_FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
